svnet_ram_reader: RTL and testbench
===================================

// Module: svnet_ram_reader
// PURPOSE
//  Read-side client of the svnet single-port-pair RAM: takes a (base, count) burst command, issues RAM reads,
//  collects the fixed-latency responses and presents them as a valid/ready stream with a last marker.
//  Sits between a layer buffer RAM and the downstream convolution/pooling datapath; credit-based so no beat is lost.
// PARAMETERS
//  DEPTH         1024  RAM words; AW = $clog2(DEPTH), CW = $clog2(DEPTH+1)
//  WIDTH         16    RAM word / stream data width
//  READ_LATENCY  2     cycles from ram_read to ram_read_data_valid (fixed by the RAM)
//  ISSUE_GAP     2     min cycles between successive ram_read pulses (1 = back-to-back)
//  FIFO_DEPTH    4     response buffer entries, >= READ_LATENCY, power of two
// PORTS
//  clk                  in   1      clock
//  rst                  in   1      synchronous, active-high reset
//  cmd_valid            in   1      burst command offered
//  cmd_ready            out  1      command accepted when cmd_valid && cmd_ready
//  cmd_base             in   AW     first word address
//  cmd_count            in   CW     words to read, 0 allowed
//  cmd_error            out  1      1-cycle pulse: command rejected (range error, see CONFIGURATION)
//  ram_read             out  1      RAM read strobe
//  ram_read_address     out  AW     RAM read address
//  ram_read_data_valid  in   1      RAM response strobe
//  ram_read_data        in   WIDTH  RAM response word
//  out_valid            out  1      stream beat valid
//  out_ready            in   1      stream beat accepted when out_valid && out_ready
//  out_data             out  WIDTH  stream word, address order
//  out_last             out  1      marks final beat of burst
//  done                 out  1      1-cycle pulse after last beat handshake (or on count==0 accept)
// BEHAVIOUR
//  Reset values: cmd_ready 0, cmd_error 0, ram_read 0, ram_read_address 0, out_valid 0, out_last 0, done 0,
//   out_data 0; FSM IDLE, FIFO empty, inflight 0, gap counter 0.
//  Post-reset guard: cmd_ready held 0 for READ_LATENCY cycles after rst deasserts; ram_read_data_valid
//   during guard or IDLE is discarded (flushes responses from a reads-in-flight reset).
//  FSM IDLE -> ISSUE on accepted command with count>0; count==0 accept -> done pulse next cycle, stay IDLE.
//   ISSUE: ram_read=1 iff remaining>0 && gap==0 && (inflight + fifo_used) < FIFO_DEPTH; address increments by 1.
//   ISSUE -> DRAIN when final read issued; DRAIN -> IDLE when final beat handshakes; done pulses that cycle+1.
//  cmd_ready = (state==IDLE) && guard expired; commands ignored otherwise (no queuing).
//  inflight +1 on ram_read, -1 on ram_read_data_valid, both same cycle -> unchanged; never exceeds READ_LATENCY.
//  Response pushed into FIFO same cycle as ram_read_data_valid; credit rule guarantees no overflow.
//  out_valid = FIFO non-empty; out_data/out_last stable while out_valid && !out_ready.
//  out_last = 1 on beat whose beat counter == count-1; beat counter reset on each accept.
//  Throughput: ISSUE_GAP=1, out_ready=1 -> 1 beat/cycle; first beat READ_LATENCY+1 cycles after accept.
//  Mid-burst rst: all state cleared at next edge, partial burst abandoned, no done/last emitted.
// CONFIGURATION
//  SVNET_RAM_READER_WRAP_EN defined: addresses wrap modulo DEPTH (DEPTH-1 -> 0); cmd_count>DEPTH rejected.
//  Not defined: command with cmd_base+cmd_count > DEPTH rejected: cmd_error pulse, no reads, stay IDLE,
//   no done. cmd_count>DEPTH rejected in both builds. Width of sum computed in CW+1 bits, no overflow.
// STRUCTURE
//  Package svnet_ram_reader_pkg: state enum (IDLE, ISSUE, DRAIN), addr_t/count_t typedef functions of DEPTH.
//  Sub-module svnet_ram_reader_fifo: synchronous FIFO (FIFO_DEPTH x WIDTH+1 incl. last), push/pop/used count.
//  Top holds FSM, address/remaining/gap/inflight/beat counters, credit check, guard counter.
// TESTING
//  base=10,count=4,out_ready=1,GAP=2 -> reads at 10,11,12,13 every 2 cycles; 4 beats, last on addr13, done once.
//  GAP=1,out_ready=0 for 20 cycles, count=16 -> ram_read stops after FIFO_DEPTH outstanding; no beat lost/dup.
//  count=0 -> no ram_read, done pulse cycle after accept, out_valid never 1.
//  base=DEPTH-2,count=4: WRAP_EN -> addrs DEPTH-2,DEPTH-1,0,1; else cmd_error pulse, no reads.
//  rst asserted 1 cycle mid-burst with 2 reads inflight -> stale responses dropped, cmd_ready low READ_LATENCY cycles, next burst clean.
//  Random out_ready, random cmd stream -> scoreboard vs RAM model: data order exact, one last+done per burst.

Source files
------------

// File: rtl/svnet_ram_reader_pkg.sv
// Shared types and default sizing for the svnet RAM reader.
// Build option SVNET_RAM_READER_WRAP_EN (see svnet_ram_reader.sv) changes
// addressing only; nothing here depends on it.
package svnet_ram_reader_pkg;

    localparam int RAM_DEPTH = 1024;
    localparam int RAM_AW    = $clog2(RAM_DEPTH);
    localparam int RAM_CW    = $clog2(RAM_DEPTH + 1);

    typedef logic [RAM_AW-1:0] addr_t;
    typedef logic [RAM_CW-1:0] count_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

endpackage

// File: rtl/svnet_ram_reader_fifo.sv
// Response buffer for the RAM reader: synchronous FIFO with an occupancy
// count, used by the issue side to decide whether another read may go out.
// Push on a full FIFO or pop on an empty one is never requested by the parent.
module svnet_ram_reader_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 17,
    localparam int PW   = $clog2(DEPTH),
    localparam int UW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic [UW-1:0] used
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    // Storage array: written on push, contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            used <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   used <= used + UW'(1);
                2'b01:   used <= used - UW'(1);
                default: used <= used;
            endcase
        end
    end

    assign head  = mem[rptr];
    assign empty = (used == '0);

endmodule

// File: rtl/svnet_ram_reader.sv
// svnet RAM reader: turns a (base, count) burst command into paced RAM reads
// and returns the fixed-latency responses as a valid/ready stream with a
// last marker. Reads are only issued while the response FIFO can absorb
// every outstanding response, so a stalled consumer never loses a beat.
// Build option SVNET_RAM_READER_WRAP_EN: addresses wrap modulo DEPTH and
// only counts above DEPTH are rejected; without it a burst running past
// the end of the RAM is rejected as well.
module svnet_ram_reader
    import svnet_ram_reader_pkg::*;
#(
    parameter int DEPTH        = RAM_DEPTH,
    parameter int WIDTH        = 16,
    parameter int READ_LATENCY = 2,
    parameter int ISSUE_GAP    = 2,
    parameter int FIFO_DEPTH   = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AW-1:0]    cmd_base,
    input  logic [CW-1:0]    cmd_count,
    output logic             cmd_error,
    output logic             ram_read,
    output logic [AW-1:0]    ram_read_address,
    input  logic             ram_read_data_valid,
    input  logic [WIDTH-1:0] ram_read_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             done
);
    localparam int UW = $clog2(FIFO_DEPTH + 1);
    localparam int GW = $clog2(ISSUE_GAP + 1);
    localparam int LW = $clog2(READ_LATENCY + 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   remaining;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   beat;
    logic [GW-1:0]   gap;
    logic [UW-1:0]   inflight;
    logic [UW-1:0]   fifo_used;
    logic [LW-1:0]   guard;
    logic [AW-1:0]   addr_nxt;
    logic [WIDTH:0]  fifo_head;
    logic            fifo_empty;
    logic            accept;
    logic            range_bad;
    logic            rsp_ok;
    logic            pop;
    logic            credit_ok;
    logic            push_last;

`ifdef SVNET_RAM_READER_WRAP_EN
    assign range_bad = (cmd_count > CW'(DEPTH));
    assign addr_nxt  = (ram_read_address == AW'(DEPTH - 1)) ? '0 : ram_read_address + AW'(1);
`else
    logic [CW:0] end_sum;
    assign end_sum   = (CW+1)'(cmd_base) + (CW+1)'(cmd_count);
    assign range_bad = (cmd_count > CW'(DEPTH)) || (end_sum > (CW+1)'(DEPTH));
    assign addr_nxt  = ram_read_address + AW'(1);
`endif

    // Commands are taken only in IDLE once responses from before a reset
    // have had time to drain out of the RAM pipeline.
    assign cmd_ready = (state == IDLE) && (guard == '0);
    assign accept    = cmd_valid && cmd_ready;
    // Responses seen while guarding or idle belong to an abandoned burst.
    assign rsp_ok    = ram_read_data_valid && (guard == '0) && (state != IDLE);
    assign pop       = out_valid && out_ready;
    // Every outstanding read must have a FIFO slot reserved for it.
    assign credit_ok = ((UW+1)'(inflight) + (UW+1)'(fifo_used)) < (UW+1)'(FIFO_DEPTH);
    assign push_last = (beat == count_r - CW'(1));

    // Next-state and read-strobe decode.
    always_comb begin
        state_nxt = state;
        ram_read  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !range_bad && (cmd_count != '0)) state_nxt = ISSUE;
            end
            ISSUE: begin
                ram_read = (remaining != '0) && (gap == '0) && credit_ok;
                if (ram_read && (remaining == CW'(1))) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && out_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, counters and the registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            guard            <= LW'(READ_LATENCY);
            ram_read_address <= '0;
            remaining        <= '0;
            count_r          <= '0;
            beat             <= '0;
            gap              <= '0;
            inflight         <= '0;
            done             <= 1'b0;
            cmd_error        <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_error <= accept && range_bad;
            done      <= (accept && !range_bad && (cmd_count == '0)) || (pop && out_last);
            if (guard != '0) guard <= guard - LW'(1);

            if (accept && !range_bad) begin
                ram_read_address <= cmd_base;
                remaining        <= cmd_count;
                count_r          <= cmd_count;
                beat             <= '0;
            end else begin
                if (ram_read) begin
                    ram_read_address <= addr_nxt;
                    remaining        <= remaining - CW'(1);
                end
                if (rsp_ok) beat <= beat + CW'(1);
            end

            if (ram_read)         gap <= GW'(ISSUE_GAP - 1);
            else if (gap != '0)   gap <= gap - GW'(1);

            case ({ram_read, rsp_ok})
                2'b10:   inflight <= inflight + UW'(1);
                2'b01:   inflight <= inflight - UW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    svnet_ram_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_ok),
        .push_data ({push_last, ram_read_data}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .used      (fifo_used)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_head[WIDTH-1:0];
    assign out_last  = !fifo_empty && fifo_head[WIDTH];

endmodule

// File: tb/tb_svnet_ram_reader.sv
// Bench for svnet_ram_reader: two instances (ISSUE_GAP 2 and 1) each fed by a
// fixed-latency RAM model whose word at address a is memf(a). Expected
// streams are built from the burst rules (address sequence, data, last flag).
module tb_svnet_ram_reader;
    localparam int DEPTH = 1024;
    localparam int WIDTH = 16;
    localparam int RL    = 2;
    localparam int FD    = 4;
    localparam int AW    = 10;
    localparam int CW    = 11;
    localparam int LOGN  = 4096;
`ifdef SVNET_RAM_READER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]       cmd_valid = '0;
    logic [1:0]       out_ready = '0;
    logic [1:0]       cmd_ready, cmd_error, ram_read, rdv, out_valid, out_last, done;
    logic [AW-1:0]    cmd_base  [2];
    logic [CW-1:0]    cmd_count [2];
    logic [AW-1:0]    ram_addr  [2];
    logic [WIDTH-1:0] rdd       [2];
    logic [WIDTH-1:0] out_data  [2];

    int total = 0;
    int bad   = 0;

    function automatic logic [WIDTH-1:0] memf(input int a);
        logic [31:0] h;
        h = a * 32'd40503 + 32'd7;
        return h[23:8];
    endfunction

    function automatic int exp_addr(input int base, input int i);
        return WRAP ? (base + i) % DEPTH : base + i;
    endfunction

    // RAM model: response READ_LATENCY cycles after the read strobe.
    logic [RL-1:0] pv [2] = '{default: '0};
    int            pa [2][RL];
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            pv[g]    <= {pv[g][RL-2:0], ram_read[g] === 1'b1};
            pa[g][0] <= int'(ram_addr[g]);
            for (int i = 1; i < RL; i++) pa[g][i] <= pa[g][i-1];
        end
    end
    assign rdv    = {pv[1][RL-1], pv[0][RL-1]};
    assign rdd[0] = memf(pa[0][RL-1]);
    assign rdd[1] = memf(pa[1][RL-1]);

    for (genvar g = 0; g < 2; g++) begin : g_dut
        svnet_ram_reader #(
            .DEPTH(DEPTH), .WIDTH(WIDTH), .READ_LATENCY(RL),
            .ISSUE_GAP(g == 0 ? 2 : 1), .FIFO_DEPTH(FD)
        ) dut (
            .clk(clk), .rst(rst),
            .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
            .cmd_base(cmd_base[g]), .cmd_count(cmd_count[g]), .cmd_error(cmd_error[g]),
            .ram_read(ram_read[g]), .ram_read_address(ram_addr[g]),
            .ram_read_data_valid(rdv[g]), .ram_read_data(rdd[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .out_data(out_data[g]), .out_last(out_last[g]), .done(done[g])
        );
    end

    // Event logs, sampled mid-cycle.
    int             rd_n [2] = '{0, 0};
    int             rd_a [2][LOGN];
    int             rd_c [2][LOGN];
    int             bt_n [2] = '{0, 0};
    logic [WIDTH:0] bt_v [2][LOGN];
    int             bt_c [2][LOGN];
    int             done_n [2] = '{0, 0};
    int             done_c [2] = '{0, 0};
    int             err_n  [2] = '{0, 0};
    int             err_c  [2] = '{0, 0};
    int             ov_n   [2] = '{0, 0};
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (ram_read[g] === 1'b1 && rd_n[g] < LOGN) begin
                rd_a[g][rd_n[g]] = int'(ram_addr[g]); rd_c[g][rd_n[g]] = cyc; rd_n[g]++;
            end
            if (out_valid[g] === 1'b1 && out_ready[g] && bt_n[g] < LOGN) begin
                bt_v[g][bt_n[g]] = {out_last[g], out_data[g]}; bt_c[g][bt_n[g]] = cyc; bt_n[g]++;
            end
            if (done[g] === 1'b1)      begin done_n[g]++; done_c[g] = cyc; end
            if (cmd_error[g] === 1'b1) begin err_n[g]++;  err_c[g]  = cyc; end
            if (out_valid[g] === 1'b1) ov_n[g]++;
        end
    end

    // Offer a command, wait for done/error with out_ready randomised at pct%.
    task automatic do_burst(input int s, input int base, input int cnt, input int pct,
                            output int acc, output bit tmo);
        int d0, e0, n;
        d0 = done_n[s]; e0 = err_n[s]; tmo = 1'b0; acc = -1;
        cmd_base[s] = AW'(base); cmd_count[s] = CW'(cnt); cmd_valid[s] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready[s] && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready[s]) begin tmo = 1'b1; cmd_valid[s] = 1'b0; return; end
        @(posedge clk); #1; acc = cyc; cmd_valid[s] = 1'b0;
        n = 0;
        while (done_n[s] == d0 && err_n[s] == e0 && n < 3000) begin
            out_ready[s] = ($urandom_range(99) < pct);
            @(posedge clk); #1; n++;
        end
        if (n >= 3000) tmo = 1'b1;
        out_ready[s] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Check the read addresses and beats of one finished burst.
    task automatic test_stream(input string nm, input int s, input int base, input int cnt,
                               input bit rejected, input int r0, input int b0);
        int ecnt;
        ecnt = rejected ? 0 : cnt;
        total++;
        if (rd_n[s] - r0 !== ecnt) begin bad++;
            $display("FAIL %s reads: got %0d want %0d", nm, rd_n[s] - r0, ecnt); end
        total++;
        if (bt_n[s] - b0 !== ecnt) begin bad++;
            $display("FAIL %s beats: got %0d want %0d", nm, bt_n[s] - b0, ecnt); end
        for (int i = 0; i < ecnt && i < rd_n[s] - r0; i++) begin
            total++;
            if (rd_a[s][r0+i] !== exp_addr(base, i)) begin bad++;
                $display("FAIL %s addr[%0d]: got %0d want %0d", nm, i, rd_a[s][r0+i], exp_addr(base, i)); end
        end
        for (int i = 0; i < ecnt && i < bt_n[s] - b0; i++) begin
            logic [WIDTH:0] ev;
            ev = {i == cnt - 1, memf(exp_addr(base, i))};
            total++;
            if (bt_v[s][b0+i] !== ev) begin bad++;
                $display("FAIL %s beat[%0d]: got %h want %h", nm, i, bt_v[s][b0+i], ev); end
        end
    endtask

    task automatic test_reset();
        int lows;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            total++;
            if ({cmd_ready[g], cmd_error[g], ram_read[g], out_valid[g], out_last[g], done[g]} !== 6'b0
                || ram_addr[g] !== '0 || out_data[g] !== '0) begin bad++;
                $display("FAIL reset_values[%0d]: got %b addr %0d data %0d want all zero", g,
                         {cmd_ready[g], cmd_error[g], ram_read[g], out_valid[g], out_last[g], done[g]},
                         ram_addr[g], out_data[g]);
            end
        end
        @(posedge clk); #1; rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cmd_ready[0] !== 1'b1) lows++;
            else break;
        end
        total++;
        if (lows !== RL) begin bad++; $display("FAIL reset_guard: got %0d low cycles want %0d", lows, RL); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int acc, r0, b0, d0; bit tmo;
        r0 = rd_n[0]; b0 = bt_n[0]; d0 = done_n[0];
        do_burst(0, 10, 4, 100, acc, tmo);
        total++; if (tmo) begin bad++; $display("FAIL basic_timeout: got 1 want 0"); end
        test_stream("basic", 0, 10, 4, 1'b0, r0, b0);
        for (int i = 1; i < 4; i++) begin
            total++;
            if (rd_c[0][r0+i] - rd_c[0][r0+i-1] !== 2) begin bad++;
                $display("FAIL basic_gap[%0d]: got %0d want 2", i, rd_c[0][r0+i] - rd_c[0][r0+i-1]); end
        end
        total++;
        if (bt_c[0][b0] - acc !== RL + 1) begin bad++;
            $display("FAIL basic_latency: got %0d want %0d", bt_c[0][b0] - acc, RL + 1); end
        total++;
        if (done_n[0] - d0 !== 1 || done_c[0] !== bt_c[0][b0+3] + 1) begin bad++;
            $display("FAIL basic_done: got n=%0d cyc=%0d want n=1 cyc=%0d", done_n[0] - d0, done_c[0], bt_c[0][b0+3] + 1); end
    endtask

    task automatic test_count_zero();
        int acc, r0, d0, o0; bit tmo;
        r0 = rd_n[0]; d0 = done_n[0]; o0 = ov_n[0];
        do_burst(0, 5, 0, 100, acc, tmo);
        total++;
        if (tmo || rd_n[0] != r0 || ov_n[0] != o0) begin bad++;
            $display("FAIL zero_quiet: got tmo=%0d reads=%0d valid=%0d want 0 0 0", tmo, rd_n[0] - r0, ov_n[0] - o0); end
        total++;
        if (done_n[0] - d0 !== 1 || done_c[0] !== acc) begin bad++;
            $display("FAIL zero_done: got n=%0d cyc=%0d want n=1 cyc=%0d", done_n[0] - d0, done_c[0], acc); end
    endtask

    task automatic test_wrap();
        int acc, r0, b0, d0, e0; bit tmo;
        // Ends exactly at the top: always legal.
        r0 = rd_n[0]; b0 = bt_n[0]; e0 = err_n[0];
        do_burst(0, DEPTH - 4, 4, 100, acc, tmo);
        test_stream("edge", 0, DEPTH - 4, 4, 1'b0, r0, b0);
        total++; if (tmo || err_n[0] != e0) begin bad++; $display("FAIL edge_err: got %0d want 0", err_n[0] - e0); end
        // Crosses the top: wraps or is rejected.
        r0 = rd_n[0]; b0 = bt_n[0]; d0 = done_n[0]; e0 = err_n[0];
        do_burst(0, DEPTH - 2, 4, 100, acc, tmo);
        test_stream("cross", 0, DEPTH - 2, 4, !WRAP, r0, b0);
        total++;
        if (tmo || err_n[0] - e0 !== int'(!WRAP) || done_n[0] - d0 !== int'(WRAP)) begin bad++;
            $display("FAIL cross_status: got err=%0d done=%0d want err=%0d done=%0d",
                     err_n[0] - e0, done_n[0] - d0, !WRAP, WRAP); end
        // Count above DEPTH: rejected in every build, error pulse the cycle after accept.
        r0 = rd_n[0]; d0 = done_n[0]; e0 = err_n[0];
        do_burst(0, 0, DEPTH + 1, 100, acc, tmo);
        total++;
        if (tmo || err_n[0] - e0 !== 1 || err_c[0] !== acc || rd_n[0] != r0 || done_n[0] != d0) begin bad++;
            $display("FAIL toolong: got err=%0d cyc=%0d reads=%0d done=%0d want 1 %0d 0 0",
                     err_n[0] - e0, err_c[0], rd_n[0] - r0, done_n[0] - d0, acc); end
    endtask

    task automatic test_stall();
        int r0, b0, d0, n;
        r0 = rd_n[1]; b0 = bt_n[1]; d0 = done_n[1];
        out_ready[1] = 1'b0; cmd_base[1] = AW'(100); cmd_count[1] = CW'(16); cmd_valid[1] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready[1] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1; cmd_valid[1] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++;
        if (rd_n[1] - r0 !== FD || bt_n[1] != b0) begin bad++;
            $display("FAIL stall_credit: got reads=%0d beats=%0d want %0d 0", rd_n[1] - r0, bt_n[1] - b0, FD); end
        total++;
        if (out_valid[1] !== 1'b1 || out_data[1] !== memf(100) || out_last[1] !== 1'b0) begin bad++;
            $display("FAIL stall_hold: got v=%b d=%h l=%b want 1 %h 0", out_valid[1], out_data[1], out_last[1], memf(100)); end
        @(posedge clk); #1; out_ready[1] = 1'b1;
        n = 0;
        while (done_n[1] == d0 && n < 300) begin @(posedge clk); #1; n++; end
        out_ready[1] = 1'b0;
        total++; if (n >= 300) begin bad++; $display("FAIL stall_timeout: got %0d cycles want <300", n); end
        test_stream("stall", 1, 100, 16, 1'b0, r0, b0);
    endtask

    task automatic test_back_to_back();
        int acc, r0, b0; bit tmo;
        r0 = rd_n[1]; b0 = bt_n[1];
        do_burst(1, 300, 8, 100, acc, tmo);
        test_stream("b2b", 1, 300, 8, 1'b0, r0, b0);
        for (int i = 1; i < 8; i++) begin
            total++;
            if (rd_c[1][r0+i] - rd_c[1][r0+i-1] !== 1 || bt_c[1][b0+i] - bt_c[1][b0+i-1] !== 1) begin bad++;
                $display("FAIL b2b_rate[%0d]: got read gap %0d beat gap %0d want 1 1", i,
                         rd_c[1][r0+i] - rd_c[1][r0+i-1], bt_c[1][b0+i] - bt_c[1][b0+i-1]); end
        end
        total++;
        if (bt_c[1][b0] - acc !== RL + 1) begin bad++;
            $display("FAIL b2b_latency: got %0d want %0d", bt_c[1][b0] - acc, RL + 1); end
    endtask

    task automatic test_mid_reset();
        int acc, r0, b0, d0, n, lows; bit tmo;
        r0 = rd_n[1]; b0 = bt_n[1]; d0 = done_n[1];
        out_ready[1] = 1'b1; cmd_base[1] = AW'(50); cmd_count[1] = CW'(8); cmd_valid[1] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready[1] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1; cmd_valid[1] = 1'b0;
        n = 0;
        while (rd_n[1] - r0 < 2 && n < 20) begin @(posedge clk); #1; n++; end
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cmd_ready[1] !== 1'b1) lows++;
            else break;
        end
        total++;
        if (lows !== RL) begin bad++; $display("FAIL midrst_guard: got %0d low cycles want %0d", lows, RL); end
        repeat (4) @(negedge clk);
        total++;
        if (bt_n[1] != b0 || done_n[1] != d0 || out_valid[1] !== 1'b0) begin bad++;
            $display("FAIL midrst_flush: got beats=%0d done=%0d valid=%b want 0 0 0",
                     bt_n[1] - b0, done_n[1] - d0, out_valid[1]); end
        @(posedge clk); #1;
        r0 = rd_n[1]; b0 = bt_n[1]; d0 = done_n[1];
        do_burst(1, 200, 5, 100, acc, tmo);
        test_stream("midrst_next", 1, 200, 5, 1'b0, r0, b0);
        total++;
        if (tmo || done_n[1] - d0 !== 1) begin bad++;
            $display("FAIL midrst_done: got %0d want 1", done_n[1] - d0); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            int s, base, cnt, pct, acc, r0, b0, d0, e0; bit tmo, rej;
            s    = int'($urandom_range(1));
            base = ($urandom_range(4) == 0) ? DEPTH - int'($urandom_range(8, 1)) : int'($urandom_range(DEPTH - 1));
            cnt  = int'($urandom_range(12));
            pct  = int'($urandom_range(90, 30));
            rej  = (cnt > DEPTH) || (!WRAP && base + cnt > DEPTH);
            r0 = rd_n[s]; b0 = bt_n[s]; d0 = done_n[s]; e0 = err_n[s];
            do_burst(s, base, cnt, pct, acc, tmo);
            total++;
            if (tmo || err_n[s] - e0 !== int'(rej) || done_n[s] - d0 !== int'(!rej)) begin bad++;
                $display("FAIL rand%0d_status: got tmo=%0d err=%0d done=%0d want 0 %0d %0d",
                         k, tmo, err_n[s] - e0, done_n[s] - d0, rej, !rej); end
            test_stream("rand", s, base, cnt, rej, r0, b0);
        end
    endtask

    initial begin
        cmd_base  = '{default: '0};
        cmd_count = '{default: '0};
        test_reset();
        test_basic();
        test_count_zero();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
